// File: rtl/brisc_pkg.sv
// Shared types and default sizes for the brisc memory stage.
package brisc_pkg;

  localparam int XLEN            = 32;
  localparam int ADDRESS_WIDTH   = 32;
  localparam int NUM_STB_ENTRIES = 4;

  typedef enum logic [1:0] {
    OTHER    = 2'd0,
    IS_STORE = 2'd1,
    IS_LOAD  = 2'd2
  } stb_ctrl_e;

  typedef enum logic {
    B = 1'b0,
    W = 1'b1
  } data_size_e;

  typedef enum logic {
    NO_XCPT       = 1'b0,
    MEM_UNALIGNED = 1'b1
  } xcpt_e;

endpackage

// File: rtl/store_buffer.sv
// Circular store buffer between the memory stage and the data cache, with
// store-to-load forwarding from the youngest matching entry.
module store_buffer
  import brisc_pkg::*;
#(
  parameter int NUM_ENTRIES   = NUM_STB_ENTRIES,
  parameter int XLEN          = brisc_pkg::XLEN,
  parameter int ADDRESS_WIDTH = brisc_pkg::ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid_i,
  input  stb_ctrl_e                req_ctrl_i,
  input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
  input  logic [XLEN-1:0]          req_data_i,
  input  data_size_e               req_size_i,
  input  logic                     flush_i,
  output logic                     stall_o,
  output xcpt_e                    xcpt_o,
  output logic                     fwd_hit_o,
  output logic [XLEN-1:0]          fwd_data_o,
  output logic                     drain_valid_o,
  output logic [ADDRESS_WIDTH-1:0] drain_addr_o,
  output logic [XLEN-1:0]          drain_data_o,
  output data_size_e               drain_size_o,
  input  logic                     drain_ready_i,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int PTR_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_ENTRIES);

  logic [ADDRESS_WIDTH-1:0] addr_q [NUM_ENTRIES];
  logic [XLEN-1:0]          data_q [NUM_ENTRIES];
  data_size_e               size_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic unaligned, is_store, is_load, push, pop;
  logic hit_found, fwd_ok, conflict;
  logic [PTR_W-1:0] hit_idx;
  logic [XLEN-1:0]  shifted;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);

  assign unaligned = req_valid_i && (req_size_i == W) && (req_addr_i[1:0] != 2'b00) &&
                     ((req_ctrl_i == IS_STORE) || (req_ctrl_i == IS_LOAD));
  assign xcpt_o    = unaligned ? MEM_UNALIGNED : NO_XCPT;
  assign is_store  = req_valid_i && (req_ctrl_i == IS_STORE) && !unaligned;
  assign is_load   = req_valid_i && (req_ctrl_i == IS_LOAD) && !unaligned;

  // Drain handshake: the head entry transfers on any cycle with
  // drain_valid_o && drain_ready_i; drain_valid_o never looks at drain_ready_i.
  // A pending load holds the cache port unless flush_i forces the drain.
  assign drain_valid_o = !empty_o && (flush_i || !req_valid_i || (req_ctrl_i != IS_LOAD));
  assign pop           = drain_valid_o && drain_ready_i;
  assign drain_addr_o  = empty_o ? '0 : addr_q[head_q];
  assign drain_data_o  = empty_o ? '0 : data_q[head_q];
  assign drain_size_o  = empty_o ? B  : size_q[head_q];

  // Walk entries oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit_found = 1'b0;
    hit_idx   = '0;
    idx       = head_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && (addr_q[idx][ADDRESS_WIDTH-1:2] == req_addr_i[ADDRESS_WIDTH-1:2])) begin
        hit_found = 1'b1;
        hit_idx   = idx;
      end
    end
  end

  // A word entry can serve any load; a byte entry serves only an identical byte load.
  assign fwd_ok    = (size_q[hit_idx] == W) ||
                     ((req_size_i == B) && (addr_q[hit_idx] == req_addr_i));
  assign conflict  = is_load && hit_found && !fwd_ok;
  assign fwd_hit_o = is_load && hit_found && fwd_ok;

  always_comb begin
    shifted    = data_q[hit_idx] >> {req_addr_i[1:0], 3'b000};
    fwd_data_o = '0;
    if (fwd_hit_o) begin
      if (req_size_i == W) begin
        fwd_data_o = data_q[hit_idx];
      end else if (size_q[hit_idx] == W) begin
        fwd_data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      end else begin
        fwd_data_o = {{(XLEN-8){1'b0}}, data_q[hit_idx][7:0]};
      end
    end
  end

  assign stall_o = (is_store && full_o && !pop) || (flush_i && !empty_o) || conflict;
  assign push    = is_store && !stall_o;

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= req_addr_i;
      data_q[tail_q] <= req_data_i;
      size_q[tail_q] <= req_size_i;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, hand-written corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_store_buffer;
  import brisc_pkg::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  stb_ctrl_e   req_ctrl_i = OTHER;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_data_i = '0;
  data_size_e  req_size_i = W;
  logic        flush_i = 1'b0;
  logic        drain_ready_i = 1'b0;
  logic        stall_o, fwd_hit_o, drain_valid_o, empty_o, full_o;
  xcpt_e       xcpt_o;
  logic [31:0] fwd_data_o, drain_addr_o, drain_data_o;
  data_size_e  drain_size_o;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered stores in program order, oldest at index 0.
  logic [31:0] exp_q[$];
  logic [31:0] addr_mq[$];
  data_size_e  size_mq[$];

  store_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ctrl_i(req_ctrl_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_size_i(req_size_i), .flush_i(flush_i),
    .stall_o(stall_o), .xcpt_o(xcpt_o), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
    .drain_valid_o(drain_valid_o), .drain_addr_o(drain_addr_o), .drain_data_o(drain_data_o),
    .drain_size_o(drain_size_o), .drain_ready_i(drain_ready_i),
    .empty_o(empty_o), .full_o(full_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    stb_ctrl_e   ctrl;
    data_size_e  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic        dr;
    logic        e_stall;
    logic        e_xcpt;
    logic        e_hit;
    logic [31:0] e_fd;
    logic        e_dv;
    logic [31:0] e_da;
    logic [31:0] e_dd;
    logic        e_full;
    logic        e_empty;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input stb_ctrl_e c, input data_size_e s,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic dr, input logic fl);
    req_valid_i   = v;
    req_ctrl_i    = c;
    req_size_i    = s;
    req_addr_i    = a;
    req_data_i    = d;
    drain_ready_i = dr;
    flush_i       = fl;
  endtask

  function automatic vec_t mk(logic v, stb_ctrl_e c, data_size_e s, logic [31:0] a,
                              logic [31:0] d, logic dr, logic es, logic ex, logic eh,
                              logic [31:0] efd, logic edv, logic [31:0] eda,
                              logic [31:0] edd, logic ef, logic ee);
    vec_t r;
    r.v = v; r.ctrl = c; r.size = s; r.addr = a; r.data = d; r.dr = dr;
    r.e_stall = es; r.e_xcpt = ex; r.e_hit = eh; r.e_fd = efd; r.e_dv = edv;
    r.e_da = eda; r.e_dd = edd; r.e_full = ef; r.e_empty = ee;
    return r;
  endfunction

  initial begin
    logic exp_x, exp_dv, exp_stall, exp_hit, exp_conf, is_st, is_ld, exp_pop, exp_push;
    logic [31:0] exp_fd, ent_d, ent_a;
    logic [7:0]  bytes4 [4];
    int          m;

    // reset state
    #2;
    check("reset empty", 32'(empty_o), 32'd1);
    check("reset full", 32'(full_o), 32'd0);
    check("reset drain_valid", 32'(drain_valid_o), 32'd0);
    check("reset stall", 32'(stall_o), 32'd0);
    check("reset fwd_hit", 32'(fwd_hit_o), 32'd0);
    check("reset xcpt", 32'(xcpt_o), 32'(NO_XCPT));
    @(negedge clk);
    rst_n = 1'b1;

    //            v  ctrl      sz addr        data          dr st x  hit fd          dv da          dd            fu em
    vecs.push_back(mk(1, IS_STORE, W, 32'h100, 32'h11,       0, 0, 0, 0, 32'h0,  0, 32'h0,   32'h0,        0, 1));
    vecs.push_back(mk(1, IS_STORE, W, 32'h104, 32'h22,       0, 0, 0, 0, 32'h0,  1, 32'h100, 32'h11,       0, 0));
    vecs.push_back(mk(1, IS_STORE, W, 32'h108, 32'h33,       0, 0, 0, 0, 32'h0,  1, 32'h100, 32'h11,       0, 0));
    vecs.push_back(mk(1, IS_STORE, W, 32'h10C, 32'h44,       0, 0, 0, 0, 32'h0,  1, 32'h100, 32'h11,       0, 0));
    vecs.push_back(mk(1, IS_STORE, W, 32'h110, 32'h55,       0, 1, 0, 0, 32'h0,  1, 32'h100, 32'h11,       1, 0));
    vecs.push_back(mk(1, IS_STORE, W, 32'h110, 32'h55,       1, 0, 0, 0, 32'h0,  1, 32'h100, 32'h11,       1, 0));
    vecs.push_back(mk(0, OTHER,    W, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,  1, 32'h104, 32'h22,       1, 0));
    vecs.push_back(mk(0, OTHER,    W, 32'h0,   32'h0,        1, 0, 0, 0, 32'h0,  1, 32'h104, 32'h22,       1, 0));
    vecs.push_back(mk(0, OTHER,    W, 32'h0,   32'h0,        1, 0, 0, 0, 32'h0,  1, 32'h108, 32'h33,       0, 0));
    vecs.push_back(mk(0, OTHER,    W, 32'h0,   32'h0,        1, 0, 0, 0, 32'h0,  1, 32'h10C, 32'h44,       0, 0));
    vecs.push_back(mk(0, OTHER,    W, 32'h0,   32'h0,        1, 0, 0, 0, 32'h0,  1, 32'h110, 32'h55,       0, 0));
    vecs.push_back(mk(0, OTHER,    W, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,  0, 32'h0,   32'h0,        0, 1));
    vecs.push_back(mk(1, IS_STORE, W, 32'h200, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,  0, 32'h0,   32'h0,        0, 1));
    vecs.push_back(mk(1, IS_LOAD,  B, 32'h201, 32'h0,        0, 0, 0, 1, 32'hBE, 0, 32'h200, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(1, IS_STORE, W, 32'h400, 32'h1,        0, 0, 0, 0, 32'h0,  1, 32'h200, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(1, IS_STORE, W, 32'h400, 32'h2,        0, 0, 0, 0, 32'h0,  1, 32'h200, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(1, IS_LOAD,  W, 32'h400, 32'h0,        0, 0, 0, 1, 32'h2,  0, 32'h200, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(1, IS_STORE, W, 32'h503, 32'h77,       0, 0, 1, 0, 32'h0,  1, 32'h200, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(1, IS_LOAD,  W, 32'h502, 32'h0,        0, 0, 1, 0, 32'h0,  0, 32'h200, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(1, IS_LOAD,  B, 32'h503, 32'h0,        0, 0, 0, 0, 32'h0,  0, 32'h200, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(0, OTHER,    W, 32'h0,   32'h0,        1, 0, 0, 0, 32'h0,  1, 32'h200, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(0, OTHER,    W, 32'h0,   32'h0,        1, 0, 0, 0, 32'h0,  1, 32'h400, 32'h1,        0, 0));
    vecs.push_back(mk(0, OTHER,    W, 32'h0,   32'h0,        1, 0, 0, 0, 32'h0,  1, 32'h400, 32'h2,        0, 0));
    vecs.push_back(mk(0, OTHER,    W, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,  0, 32'h0,   32'h0,        0, 1));

    foreach (vecs[r]) begin
      drive(vecs[r].v, vecs[r].ctrl, vecs[r].size, vecs[r].addr, vecs[r].data, vecs[r].dr, 1'b0);
      #1;
      check($sformatf("row%0d stall", r), 32'(stall_o), 32'(vecs[r].e_stall));
      check($sformatf("row%0d xcpt", r), 32'(xcpt_o), 32'(vecs[r].e_xcpt));
      check($sformatf("row%0d fwd_hit", r), 32'(fwd_hit_o), 32'(vecs[r].e_hit));
      check($sformatf("row%0d fwd_data", r), fwd_data_o, vecs[r].e_fd);
      check($sformatf("row%0d drain_valid", r), 32'(drain_valid_o), 32'(vecs[r].e_dv));
      check($sformatf("row%0d drain_addr", r), drain_addr_o, vecs[r].e_da);
      check($sformatf("row%0d drain_data", r), drain_data_o, vecs[r].e_dd);
      check($sformatf("row%0d full", r), 32'(full_o), 32'(vecs[r].e_full));
      check($sformatf("row%0d empty", r), 32'(empty_o), 32'(vecs[r].e_empty));
      @(negedge clk);
    end

    // byte store followed by a conflicting word load: stalls until flushed out
    drive(1, IS_STORE, B, 32'h300, 32'h5A, 1, 0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      drive(1, IS_LOAD, W, 32'h300, 32'h0, 1, 0);
      #1;
      check($sformatf("conflict%0d stall", k), 32'(stall_o), 32'd1);
      check($sformatf("conflict%0d fwd_hit", k), 32'(fwd_hit_o), 32'd0);
      check($sformatf("conflict%0d drain_valid", k), 32'(drain_valid_o), 32'd0);
      @(negedge clk);
    end
    drive(1, IS_LOAD, W, 32'h300, 32'h0, 1, 1);
    #1;
    check("conflict flush drain_valid", 32'(drain_valid_o), 32'd1);
    check("conflict flush drain_data", drain_data_o, 32'h5A);
    check("conflict flush drain_size", 32'(drain_size_o), 32'(B));
    @(negedge clk);
    drive(1, IS_LOAD, W, 32'h300, 32'h0, 1, 0);
    #1;
    check("conflict after stall", 32'(stall_o), 32'd0);
    check("conflict after fwd_hit", 32'(fwd_hit_o), 32'd0);
    check("conflict after empty", 32'(empty_o), 32'd1);
    @(negedge clk);

    // asynchronous reset with three buffered stores
    for (int k = 0; k < 3; k++) begin
      drive(1, IS_STORE, W, 32'h700 + 32'(4 * k), 32'(k + 1), 0, 0);
      @(negedge clk);
    end
    drive(0, OTHER, W, 32'h0, 32'h0, 0, 0);
    #1;
    check("prereset empty", 32'(empty_o), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset empty", 32'(empty_o), 32'd1);
    check("async reset drain_valid", 32'(drain_valid_o), 32'd0);
    check("async reset full", 32'(full_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    addr_mq.delete();
    size_mq.delete();

    // random traffic against the reference model
    for (int cyc = 0; cyc < 800; cyc++) begin
      stb_ctrl_e c;
      c = stb_ctrl_e'($urandom_range(0, 2));
      drive($urandom_range(0, 3) != 0, c, data_size_e'($urandom_range(0, 1)),
            32'h600 + 32'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)),
            (c != IS_STORE) && ($urandom_range(0, 9) == 0));

      exp_x  = req_valid_i && (req_ctrl_i != OTHER) && (req_size_i == W) && (req_addr_i[1:0] != 2'b00);
      is_st  = req_valid_i && (req_ctrl_i == IS_STORE) && !exp_x;
      is_ld  = req_valid_i && (req_ctrl_i == IS_LOAD) && !exp_x;
      exp_dv = (exp_q.size() > 0) && (flush_i || !req_valid_i || (req_ctrl_i != IS_LOAD));
      exp_pop = exp_dv && drain_ready_i;

      m = -1;
      for (int j = exp_q.size() - 1; j >= 0; j--)
        if (m < 0 && (addr_mq[j][31:2] == req_addr_i[31:2])) m = j;
      exp_hit  = 1'b0;
      exp_conf = 1'b0;
      exp_fd   = '0;
      if (is_ld && m >= 0) begin
        ent_d = exp_q[m];
        ent_a = addr_mq[m];
        for (int b = 0; b < 4; b++) bytes4[b] = ent_d[8*b +: 8];
        if (size_mq[m] == W && req_size_i == W) begin
          exp_hit = 1'b1;
          exp_fd  = ent_d;
        end else if (size_mq[m] == W) begin
          exp_hit = 1'b1;
          exp_fd  = {24'h0, bytes4[req_addr_i[1:0]]};
        end else if (req_size_i == B && ent_a == req_addr_i) begin
          exp_hit = 1'b1;
          exp_fd  = {24'h0, bytes4[0]};
        end else begin
          exp_conf = 1'b1;
        end
      end
      exp_stall = (is_st && exp_q.size() == N && !exp_pop) ||
                  (flush_i && exp_q.size() > 0) || exp_conf;
      exp_push  = is_st && !exp_stall;

      #1;
      check($sformatf("rnd%0d xcpt", cyc), 32'(xcpt_o), 32'(exp_x));
      check($sformatf("rnd%0d stall", cyc), 32'(stall_o), 32'(exp_stall));
      check($sformatf("rnd%0d fwd_hit", cyc), 32'(fwd_hit_o), 32'(exp_hit));
      check($sformatf("rnd%0d fwd_data", cyc), fwd_data_o, exp_fd);
      check($sformatf("rnd%0d drain_valid", cyc), 32'(drain_valid_o), 32'(exp_dv));
      check($sformatf("rnd%0d full", cyc), 32'(full_o), 32'(exp_q.size() == N));
      check($sformatf("rnd%0d empty", cyc), 32'(empty_o), 32'(exp_q.size() == 0));
      if (exp_q.size() > 0) begin
        check($sformatf("rnd%0d drain_addr", cyc), drain_addr_o, addr_mq[0]);
        check($sformatf("rnd%0d drain_data", cyc), drain_data_o, exp_q[0]);
        check($sformatf("rnd%0d drain_size", cyc), 32'(drain_size_o), 32'(size_mq[0]));
      end

      if (exp_pop) begin
        void'(exp_q.pop_front());
        void'(addr_mq.pop_front());
        void'(size_mq.pop_front());
      end
      if (exp_push) begin
        exp_q.push_back(req_data_i);
        addr_mq.push_back(req_addr_i);
        size_mq.push_back(req_size_i);
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
